coefficient_rf_stream_sequencer: RTL and testbench

//  Owns the single-port coefficient RF (part1/part2/spin-polarity macros, one shared address/web).

---
 rtl/coefficient_rf_stream_sequencer.sv | 159 +++++++++++++++
 tb/tb_coefficient_rf_stream_sequencer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/coefficient_rf_stream_sequencer.sv
// coefficient_rf_stream_sequencer
//   Owns the single-port coefficient RF (part1 / part2 / spin-polarity macros
//   sharing one address and write strobe). Each cycle grants the RF either to
//   the GPIO loader (row write) or to the read sequencer. On start, the
//   sequencer reads rows 0..NUM_ROWS-1 in order and presents each one to the
//   spin-array programmer over a valid/ready stream. Loader writes normally win
//   over a pending read, but only for STARVE_LIMIT consecutive cycles.
//
// Ports
//   i_clk, i_rst            clock, synchronous active-high reset
//   start, abort            run control pulses (abort wins)
//   wr_req/wr_addr/wr_data  loader write request; wr_gnt = write taken this edge
//   st_valid/st_ready       row stream handshake
//   st_data/st_addr/st_last registered row, its index, last-row flag
//   busy, done              run in progress, 1-cycle completion pulse
//   rf_a/rf_web/rf_bweb/rf_d  RF macro address, write strobes (active low), data
//   rf_q                    RF read data, valid the cycle after a read access
module coefficient_rf_stream_sequencer #(
  parameter int NUM_ROWS     = 50,
  parameter int AW           = 6,
  parameter int W            = 306,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          start,
  input  logic          abort,
  input  logic          wr_req,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  output logic          wr_gnt,
  output logic          st_valid,
  input  logic          st_ready,
  output logic [W-1:0]  st_data,
  output logic [AW-1:0] st_addr,
  output logic          st_last,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] rf_a,
  output logic          rf_web,
  output logic [W-1:0]  rf_bweb,
  output logic [W-1:0]  rf_d,
  input  logic [W-1:0]  rf_q
);

  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [AW-1:0] LAST_ROW   = AW'(NUM_ROWS - 1);
  localparam logic [AW:0]   ROW_LIMIT  = (AW + 1)'(NUM_ROWS);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_e;

  state_e          state_q;
  logic [AW-1:0]   row_q;
  logic [SW-1:0]   starve_q, starve_d;
  logic            st_valid_q, busy_q, done_q;
  logic [W-1:0]    st_data_q;
  logic [AW-1:0]   st_addr_q;

  logic            read_sel;
  logic            wr_en;

  function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
    return (v == STARVE_MAX) ? v : v + SW'(1);
  endfunction

  // Arbitration: one RF access per cycle. Nothing is granted while in reset.
  always_comb begin
    read_sel = 1'b0;
    wr_gnt   = 1'b0;
    wr_en    = 1'b0;
    rf_a     = '0;
    if (!i_rst) begin
      read_sel = (state_q == ISSUE) && (!wr_req || (starve_q == STARVE_MAX));
      wr_gnt   = wr_req && !read_sel;
      // Out-of-range rows are acknowledged so the loader moves on, but never
      // reach the macro.
      wr_en    = wr_gnt && ({1'b0, wr_addr} < ROW_LIMIT);
      if (read_sel)    rf_a = row_q;
      else if (wr_gnt) rf_a = wr_addr;
    end
  end

  always_comb begin
    starve_d = '0;
    if (state_q == ISSUE && !read_sel && wr_gnt) starve_d = sat_inc(starve_q);
  end

  assign rf_web  = !wr_en;
  assign rf_bweb = {W{rf_web}};
  assign rf_d    = wr_data;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      row_q      <= '0;
      starve_q   <= '0;
      st_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      st_data_q  <= '0;
      st_addr_q  <= '0;
    end else begin
      done_q   <= 1'b0;
      starve_q <= starve_d;
      if (abort) begin
        // Any read in flight is simply never captured.
        state_q    <= IDLE;
        row_q      <= '0;
        starve_q   <= '0;
        st_valid_q <= 1'b0;
        busy_q     <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            // done_q high means this is the completion cycle: start waits a cycle.
            if (start && !done_q) begin
              state_q <= ISSUE;
              row_q   <= '0;
              busy_q  <= 1'b1;
            end
          end
          ISSUE: begin
            if (read_sel) state_q <= WAIT;
          end
          WAIT: begin
            st_data_q  <= rf_q;
            st_addr_q  <= row_q;
            st_valid_q <= 1'b1;
            state_q    <= HOLD;
          end
          HOLD: begin
            if (st_ready) begin
              st_valid_q <= 1'b0;
              if (row_q == LAST_ROW) begin
                state_q <= IDLE;
                row_q   <= '0;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                row_q   <= row_q + AW'(1);
                state_q <= ISSUE;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign st_valid = st_valid_q;
  assign st_data  = st_data_q;
  assign st_addr  = st_addr_q;
  assign st_last  = st_valid_q && (st_addr_q == LAST_ROW);
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_coefficient_rf_stream_sequencer.sv
module tb_coefficient_rf_stream_sequencer;

  localparam int NUM_ROWS     = 50;
  localparam int AW           = 6;
  localparam int W            = 306;
  localparam int STARVE_LIMIT = 4;

  logic          clk = 1'b0;
  logic          i_rst, start, abort, wr_req, st_ready;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic          wr_gnt, st_valid, st_last, busy, done, rf_web;
  logic [W-1:0]  st_data, rf_bweb, rf_d;
  logic [AW-1:0] st_addr, rf_a;
  logic [W-1:0]  rf_q;

  logic [W-1:0]  mem     [64];
  logic [W-1:0]  exp_row [64];
  logic          preload;
  logic [319:0]  a5_wide;
  logic [W-1:0]  a5;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  coefficient_rf_stream_sequencer #(
    .NUM_ROWS(NUM_ROWS), .AW(AW), .W(W), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .i_clk(clk), .i_rst(i_rst), .start(start), .abort(abort),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .st_valid(st_valid), .st_ready(st_ready), .st_data(st_data),
    .st_addr(st_addr), .st_last(st_last), .busy(busy), .done(done),
    .rf_a(rf_a), .rf_web(rf_web), .rf_bweb(rf_bweb), .rf_d(rf_d), .rf_q(rf_q)
  );

  function automatic logic [W-1:0] pat(input int r);
    logic [319:0] v;
    for (int k = 0; k < 10; k++) v[k*32 +: 32] = 32'(r) * 32'h9E3779B1 + 32'(k);
    return v[W-1:0];
  endfunction

  // Single-port RF macro model: synchronous write, registered read.
  always @(posedge clk) begin
    if (preload) begin
      for (int r = 0; r < 64; r++) mem[r] <= pat(r);
    end else if (!rf_web) begin
      mem[rf_a] <= rf_d;
    end else begin
      rf_q <= mem[rf_a];
    end
  end

  task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (st_valid) break;
      @(negedge clk);
    end
    check_eq("wait_valid", st_valid, 1);
  endtask

  int gseq [14] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 1, 1, 0, 1, 1};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    i_rst = 1; preload = 1; start = 0; abort = 0; wr_req = 0; st_ready = 0;
    wr_addr = '0; wr_data = '0;
    a5_wide = {40{8'hA5}};
    a5 = a5_wide[W-1:0];
    for (int r = 0; r < 64; r++) exp_row[r] = pat(r);
    repeat (3) @(negedge clk);

    // Reset values
    check_eq("rst_st_valid", st_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_st_last", st_last, 0);
    check_eq("rst_wr_gnt", wr_gnt, 0);
    check_eq("rst_st_data", st_data, 0);
    check_eq("rst_st_addr", st_addr, 0);
    check_eq("rst_rf_web", rf_web, 1);
    check_eq("rst_rf_bweb", rf_bweb, {W{1'b1}});
    check_eq("rst_rf_a", rf_a, 0);
    i_rst = 0; preload = 0;

    // Loader writes row 5 while idle, then an out-of-range row
    wr_req = 1; wr_addr = 6'd5; wr_data = a5;
    #1;
    check_eq("wr5_gnt", wr_gnt, 1);
    check_eq("wr5_web", rf_web, 0);
    check_eq("wr5_bweb", rf_bweb, 0);
    check_eq("wr5_a", rf_a, 5);
    check_eq("wr5_d", rf_d, a5);
    exp_row[5] = a5;
    @(negedge clk);
    wr_addr = 6'd55;
    #1;
    check_eq("wr55_gnt", wr_gnt, 1);
    check_eq("wr55_web", rf_web, 1);
    check_eq("wr55_bweb", rf_bweb, {W{1'b1}});
    @(negedge clk);
    wr_req = 0;

    // Full uncontended run
    st_ready = 1; start = 1;
    @(negedge clk);
    start = 0;
    #1;
    check_eq("lat_c1_busy", busy, 1);
    check_eq("lat_c1_rf_a", rf_a, 0);
    check_eq("lat_c1_web", rf_web, 1);
    check_eq("lat_c1_valid", st_valid, 0);
    @(negedge clk);
    check_eq("lat_c2_valid", st_valid, 0);
    @(negedge clk);
    check_eq("lat_c3_valid", st_valid, 1);
    for (int r = 0; r < NUM_ROWS; r++) begin
      wait_valid(8);
      check_eq("run_addr", st_addr, r);
      check_eq("run_data", st_data, exp_row[r]);
      check_eq("run_last", st_last, (r == NUM_ROWS - 1));
      @(negedge clk);
    end
    check_eq("done_pulse", done, 1);
    check_eq("done_busy", busy, 0);
    check_eq("done_valid", st_valid, 0);
    check_eq("done_last", st_last, 0);
    start = 1;
    @(negedge clk);
    check_eq("start_in_done_ignored", busy, 0);
    check_eq("done_one_cycle", done, 0);
    @(negedge clk);
    check_eq("start_after_done", busy, 1);
    start = 0; abort = 1;
    @(negedge clk);
    abort = 0;
    check_eq("abort_busy", busy, 0);

    // Write pressure against reads: 4 grants then a read, repeating
    wr_req = 1; wr_addr = 6'd60; start = 1;
    #1;
    check_eq("idle_wr_wins", wr_gnt, 1);
    @(negedge clk);
    start = 0;
    for (int i = 0; i < 14; i++) begin
      #1;
      check_eq("starve_gnt", wr_gnt, gseq[i]);
      check_eq("starve_web", rf_web, 1);
      if (gseq[i] == 0) check_eq("starve_rd_a", rf_a, (i < 6) ? 0 : 1);
      if (i < 13) @(negedge clk);
    end
    check_eq("starve_valid", st_valid, 1);
    check_eq("starve_addr", st_addr, 1);
    check_eq("starve_data", st_data, exp_row[1]);
    wr_req = 0; abort = 1;
    @(negedge clk);
    abort = 0;
    check_eq("starve_abort_valid", st_valid, 0);

    // Backpressure on row 7, abort in WAIT of row 12
    start = 1;
    @(negedge clk);
    start = 0;
    for (int r = 0; r < 12; r++) begin
      wait_valid(8);
      check_eq("bp_addr", st_addr, r);
      check_eq("bp_data", st_data, exp_row[r]);
      if (r == 7) begin
        st_ready = 0;
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          check_eq("bp_hold_valid", st_valid, 1);
          check_eq("bp_hold_addr", st_addr, 7);
          check_eq("bp_hold_data", st_data, exp_row[7]);
          start = (k == 2);
          if (k == 5) begin
            wr_req = 1; wr_addr = 6'd20; wr_data = pat(99);
            #1;
            check_eq("hold_wr_gnt", wr_gnt, 1);
            exp_row[20] = pat(99);
          end else begin
            wr_req = 0;
          end
        end
        start = 0; wr_req = 0; st_ready = 1;
      end
      @(negedge clk);
    end
    @(negedge clk);
    check_eq("wait12_valid", st_valid, 0);
    check_eq("wait12_busy", busy, 1);
    abort = 1;
    @(negedge clk);
    abort = 0;
    check_eq("abort12_busy", busy, 0);
    for (int k = 0; k < 4; k++) begin
      check_eq("abort12_valid", st_valid, 0);
      check_eq("abort12_done", done, 0);
      @(negedge clk);
    end

    // Restart from row 0, then reset while holding it
    start = 1;
    @(negedge clk);
    start = 0;
    wait_valid(8);
    st_ready = 0;
    check_eq("restart_addr", st_addr, 0);
    check_eq("restart_data", st_data, exp_row[0]);
    i_rst = 1;
    @(negedge clk);
    i_rst = 0;
    #1;
    check_eq("hrst_valid", st_valid, 0);
    check_eq("hrst_busy", busy, 0);
    check_eq("hrst_done", done, 0);
    check_eq("hrst_last", st_last, 0);
    check_eq("hrst_data", st_data, 0);
    check_eq("hrst_addr", st_addr, 0);
    check_eq("hrst_gnt", wr_gnt, 0);
    check_eq("hrst_web", rf_web, 1);
    check_eq("hrst_rf_a", rf_a, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
